// File: rtl/fmc_spi_bus_arbiter.sv
// fmc_spi_bus_arbiter: round-robin owner of the shared FMC150 SPI bus with chip-select guard time.
// Define FMC_SPI_ARB_TIMEOUT_EN to add the ownership timeout and the timeout_pulse port.
module fmc_spi_bus_arbiter #(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned GUARD     = 4,
   parameter logic        SCLK_IDLE = 1'b1,
   parameter logic [15:0] TIMEOUT   = 16'd50000
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   input  logic [NREQ-1:0] core_sclk,
   input  logic [NREQ-1:0] core_sdo,
   input  logic [NREQ-1:0] core_csb,
   output logic [NREQ-1:0] core_sdi,
   input  logic [NREQ-1:0] dev_sdi,
   output logic            spi_sclk,
   output logic            spi_sdo,
   output logic [NREQ-1:0] spi_csb,
   output logic [2:0]      owner,
   output logic            busy,
   output logic            err_sticky
`ifdef FMC_SPI_ARB_TIMEOUT_EN
   ,
   output logic            timeout_pulse
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_GUARD_IN, S_OWN, S_GUARD_OUT} state_t;

   localparam logic [7:0] GUARD_LOAD = 8'(GUARD - 1);

   state_t          r_state, w_state_nxt;
   logic [7:0]      r_cnt, w_cnt_nxt;
   logic [2:0]      r_owner, w_owner_nxt, w_pick;
   logic            w_found;
   logic [NREQ-1:0] w_req, w_own_oh, w_gnt, r_csb, r_sdi;
   logic            w_own_req, w_own_csb, w_drive, w_err, w_timeout;
   logic            r_sclk, r_sdo, r_err;

   if (NREQ < 1 || NREQ > 8 || GUARD < 1 || GUARD > 255 || TIMEOUT == 16'd0) begin : g_bad_params
      $error("fmc_spi_bus_arbiter: parameter out of range");
   end

`ifdef FMC_SPI_ARB_TIMEOUT_EN
   logic [15:0]     r_tmo_cnt;
   logic            r_tmo_pulse;
   logic [NREQ-1:0] r_mask;

   // A revoked requester stays masked until it lets go of req.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_tmo_cnt   <= '0;
         r_tmo_pulse <= 1'b0;
         r_mask      <= '0;
      end else begin
         r_tmo_cnt   <= (r_state == S_OWN) ? r_tmo_cnt + 16'd1 : '0;
         r_tmo_pulse <= w_timeout;
         r_mask      <= (r_mask & req) | (w_timeout ? w_own_oh : '0);
      end
   end

   assign w_timeout     = (r_state == S_OWN) && (r_tmo_cnt == TIMEOUT - 16'd1);
   assign w_req         = req & ~r_mask;
   assign timeout_pulse = r_tmo_pulse;
`else
   assign w_timeout = 1'b0;
   assign w_req     = req;
`endif

   always_comb begin
      w_own_oh = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_own_oh[i] = (r_owner == 3'(i));
      end
   end

   assign w_own_req = |(req & w_own_oh);
   assign w_own_csb = |(core_csb & w_own_oh);

   // First set request scanning upward from owner+1, wrapping at NREQ.
   always_comb begin
      w_pick  = r_owner;
      w_found = 1'b0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_found && w_req[i] && (i == ({29'd0, r_owner} + k) % NREQ)) begin
               w_pick  = 3'(i);
               w_found = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_owner <= 3'(NREQ - 1);
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_owner_nxt = r_owner;
      case (r_state)
         S_IDLE: begin
            if (|w_req) begin
               w_owner_nxt = w_pick;
               w_cnt_nxt   = GUARD_LOAD;
               w_state_nxt = S_GUARD_IN;
            end
         end
         S_GUARD_IN: begin
            if (!w_own_req) begin
               w_cnt_nxt   = GUARD_LOAD;
               w_state_nxt = S_GUARD_OUT;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_OWN;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_OWN: begin
            if (!w_own_req || w_timeout) begin
               w_cnt_nxt   = GUARD_LOAD;
               w_state_nxt = S_GUARD_OUT;
            end
         end
         S_GUARD_OUT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_gnt = (r_state == S_OWN) ? w_own_oh : '0;
      gnt   = w_gnt;
      owner = r_owner;
      busy  = (r_state != S_IDLE);
   end

   // Pins follow the owner only while it keeps the bus; the release cycle already parks them.
   assign w_drive = (r_state == S_OWN) && (w_state_nxt == S_OWN);
   assign w_err   = ((r_state == S_OWN) && !w_own_req && !w_own_csb) ||
                    (|(~core_csb & ~w_gnt)) || w_timeout;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sclk <= SCLK_IDLE;
         r_sdo  <= 1'b0;
         r_csb  <= '1;
         r_sdi  <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_drive) begin
            r_sclk <= |(core_sclk & w_own_oh);
            r_sdo  <= |(core_sdo & w_own_oh);
            r_csb  <= core_csb | ~w_own_oh;
            r_sdi  <= dev_sdi & w_own_oh;
         end else begin
            r_sclk <= SCLK_IDLE;
            r_sdo  <= 1'b0;
            r_csb  <= '1;
            r_sdi  <= '0;
         end
         if (w_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign spi_sclk   = r_sclk;
   assign spi_sdo    = r_sdo;
   assign spi_csb    = r_csb;
   assign core_sdi   = r_sdi;
   assign err_sticky = r_err;

endmodule

// File: tb/tb_fmc_spi_bus_arbiter.sv
// tb_fmc_spi_bus_arbiter: directed bench for fmc_spi_bus_arbiter (NREQ=2, GUARD=4).
// Grant order is tracked by a scoreboard queue; build with FMC_SPI_ARB_TIMEOUT_EN for the timeout steps.
module tb_fmc_spi_bus_arbiter;

   localparam int NREQ  = 2;
   localparam int GUARD = 4;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic [NREQ-1:0] req, gnt, core_sclk, core_sdo, core_csb, core_sdi, dev_sdi, spi_csb;
   logic            spi_sclk, spi_sdo, busy, err_sticky;
   logic [2:0]      owner;
`ifdef FMC_SPI_ARB_TIMEOUT_EN
   logic            timeout_pulse;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int sb_q[$];
   logic [NREQ-1:0] prev_gnt = '0;

   fmc_spi_bus_arbiter #(
      .NREQ(NREQ), .GUARD(GUARD), .SCLK_IDLE(1'b1), .TIMEOUT(16'd100)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .req(req), .gnt(gnt),
      .core_sclk(core_sclk), .core_sdo(core_sdo), .core_csb(core_csb),
      .core_sdi(core_sdi), .dev_sdi(dev_sdi),
      .spi_sclk(spi_sclk), .spi_sdo(spi_sdo), .spi_csb(spi_csb),
      .owner(owner), .busy(busy), .err_sticky(err_sticky)
`ifdef FMC_SPI_ARB_TIMEOUT_EN
      , .timeout_pulse(timeout_pulse)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every new grant must match the next expected owner pushed by the stimulus.
   always @(negedge CLK) begin
      if (gnt != '0 && gnt != prev_gnt) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_grant", 32'(gnt), 32'd0);
         end else begin
            int e;
            e = sb_q.pop_front();
            check("sb_grant", 32'(gnt), 32'(1 << e));
            check("sb_owner", 32'(owner), 32'(e));
         end
      end
      prev_gnt = gnt;
   end

   task automatic do_reset();
      RST_N = 1'b0; req = '0; core_csb = '1; core_sclk = '1; core_sdo = '0; dev_sdi = '0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic wait_gnt(output int idx, output int cycles, output bit csb_hi);
      cycles = 0; csb_hi = 1'b1; idx = -1;
      while (gnt == '0 && cycles < 400) begin
         @(negedge CLK);
         cycles++;
         if (gnt == '0 && spi_csb != '1) csb_hi = 1'b0;
      end
      check("grant_seen", 32'(gnt != '0), 32'd1);
      for (int i = 0; i < NREQ; i++) if (gnt[i]) idx = i;
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 50 && busy; c++) @(negedge CLK);
      check("idle_reached", 32'(busy), 32'd0);
   endtask

   // Granted core runs a short frame, closes CSB, then drops its request.
   task automatic xfer(input int idx);
      logic [NREQ-1:0] exp_csb, exp_sdi;
      core_csb[idx] = 1'b0;
      for (int b = 0; b < 3; b++) begin
         core_sclk[idx] = ~core_sclk[idx];
         core_sdo[idx]  = b[0];
         dev_sdi        = {NREQ{~b[0]}};
         @(negedge CLK);
         exp_csb = '1; exp_csb[idx] = 1'b0;
         exp_sdi = '0; exp_sdi[idx] = ~b[0];
         check("sclk_follow", 32'(spi_sclk), 32'(core_sclk[idx]));
         check("sdo_follow", 32'(spi_sdo), 32'(core_sdo[idx]));
         check("csb_owner_only", 32'(spi_csb), 32'(exp_csb));
         check("sdi_route", 32'(core_sdi), 32'(exp_sdi));
      end
      core_csb[idx] = 1'b1; core_sclk[idx] = 1'b1; core_sdo[idx] = 1'b0; dev_sdi = '0;
      @(negedge CLK);
      check("csb_release", 32'(spi_csb), 32'h3);
      req[idx] = 1'b0;
   endtask

   initial begin
      int  idx, nidx, cyc, n;
      bit  hi;

      // Reset values
      RST_N = 1'b0; req = '0; core_csb = '1; core_sclk = '1; core_sdo = '0; dev_sdi = '0;
      @(negedge CLK);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_csb", 32'(spi_csb), 32'h3);
      check("rst_sclk", 32'(spi_sclk), 32'd1);
      check("rst_sdo", 32'(spi_sdo), 32'd0);
      check("rst_sdi", 32'(core_sdi), 32'd0);
      check("rst_owner", 32'(owner), 32'(NREQ - 1));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err_sticky), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      // Single requester: first edge samples req, then GUARD guard cycles
      req = 2'b01; sb_q.push_back(0);
      wait_gnt(idx, cyc, hi);
      check("grant_latency", 32'(cyc), 32'(GUARD + 1));
      check("guard_in_csb_high", 32'(hi), 32'd1);
      if (idx >= 0) xfer(idx);
      n = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge CLK);
         if (!busy) break;
         n++;
      end
      check("guard_out_len", 32'(n), 32'(GUARD));
      check("clean_release_err", 32'(err_sticky), 32'd0);

      // Both request from reset: 0 first, then strict alternation
      do_reset();
      req = 2'b11;
      sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(0); sb_q.push_back(1);
      wait_gnt(idx, cyc, hi);
      for (int i = 0; i < 4; i++) begin
         if (idx < 0) break;
         xfer(idx);
         if (i < 3) begin
            @(negedge CLK);
            req[idx] = 1'b1;
            wait_gnt(nidx, cyc, hi);
            check("gap_csb_high", 32'(hi), 32'd1);
            if (i == 0) check("handover_gap", 32'(cyc + 1), 32'(2 * GUARD + 2));
            check("alternate", 32'(nidx != idx), 32'd1);
            idx = nidx;
         end else begin
            req = '0;
         end
      end
      wait_idle();

      // Owner drops req with CSB still low
      req = 2'b01; sb_q.push_back(0);
      wait_gnt(idx, cyc, hi);
      core_csb[0] = 1'b0;
      @(negedge CLK);
      req[0] = 1'b0;
      n = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge CLK);
         if (c == 0) begin
            check("drop_csb_high", 32'(spi_csb), 32'h3);
            check("drop_err", 32'(err_sticky), 32'd1);
            core_csb[0] = 1'b1;
         end
         if (!busy) break;
         n++;
      end
      check("drop_busy_len", 32'(n), 32'(GUARD));

      // Ungranted core pulls CSB low
      do_reset();
      check("reset_clears_err", 32'(err_sticky), 32'd0);
      core_csb[1] = 1'b0;
      @(negedge CLK);
      check("ungranted_pin", 32'(spi_csb), 32'h3);
      check("ungranted_err", 32'(err_sticky), 32'd1);
      core_csb[1] = 1'b1;

      // Asynchronous reset in the middle of core 1's frame
      do_reset();
      req = 2'b10; sb_q.push_back(1);
      wait_gnt(idx, cyc, hi);
      core_csb[1] = 1'b0;
      @(negedge CLK);
      check("pre_reset_csb", 32'(spi_csb), 32'h1);
      #2 RST_N = 1'b0;
      #1;
      check("async_rst_csb", 32'(spi_csb), 32'h3);
      check("async_rst_gnt", 32'(gnt), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      core_csb = '1; req = '0;
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

`ifdef FMC_SPI_ARB_TIMEOUT_EN
      begin
         int own, pulses;
         bit regrant;
         do_reset();
         req = 2'b01; sb_q.push_back(0);
         wait_gnt(idx, cyc, hi);
         own = 1; pulses = 0; regrant = 1'b0;
         for (int c = 0; c < 200 && gnt[0]; c++) begin
            @(negedge CLK);
            pulses += int'(timeout_pulse);
            if (gnt[0]) own++;
         end
         for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            pulses += int'(timeout_pulse);
            if (gnt != '0) regrant = 1'b1;
         end
         check("tmo_own_cycles", 32'(own), 32'd100);
         check("tmo_pulse_count", 32'(pulses), 32'd1);
         check("tmo_masked", 32'(regrant), 32'd0);
         check("tmo_err", 32'(err_sticky), 32'd1);
         req[0] = 1'b0;
         @(negedge CLK);
         req[0] = 1'b1; sb_q.push_back(0);
         wait_gnt(idx, cyc, hi);
         req = '0;
         wait_idle();
      end
`endif

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
